// File: rtl/spi_slave_link.sv
// -----------------------------------------------------------------------------
// spi_slave_link
//   SPI mode-0 slave front-end. The host pins are oversampled in the clk domain.
//   Each frame is split into a command byte and a rolling 64-bit payload.
//   During the same frame, the decoder's 64-bit response is shifted out on MISO,
//   starting with byte 0 (txdata[7:0]) and sending each byte MSB first.
//
//   Optional feature macro: SPI_RXBYTE_STREAM_EN
//     Adds spi_rxbyte/spi_rxbyte_valid, a per-payload-byte stream.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   spi_sclk/ssel_n/mosi host pins (asynchronous to clk)
//   spi_miso             slave data to host
//   spi_cmd              first byte of current/last frame
//   spi_rxdata           payload, newest byte in [63:56]
//   spi_msg_end          one-clk pulse when a frame with a command closes
//   spi_txdata/_valid    decoder response for the current spi_cmd
//   spi_rxbyte/_valid    (optional) completed payload byte + 1-clk strobe
// -----------------------------------------------------------------------------
module spi_slave_link #(
  parameter int SYNC_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_ssel_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [7:0]  spi_cmd,
  output logic [63:0] spi_rxdata,
  output logic        spi_msg_end,
  input  logic [63:0] spi_txdata,
  input  logic        spi_txdata_valid
`ifdef SPI_RXBYTE_STREAM_EN
  ,
  output logic [7:0]  spi_rxbyte,
  output logic        spi_rxbyte_valid
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ssel_sync_q, ssel_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ssel_prev_q, ssel_prev_d;
  logic                   mosi_prev_q, mosi_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             rx_sr_q, rx_sr_d;
  logic [63:0]            tx_sr_q, tx_sr_d;
  logic                   load_pend_q, load_pend_d;
  logic                   miso_q, miso_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [63:0]            rxdata_q, rxdata_d;
  logic                   msg_end_q, msg_end_d;
`ifdef SPI_RXBYTE_STREAM_EN
  logic [7:0]             rxbyte_q, rxbyte_d;
  logic                   rxbyte_valid_q, rxbyte_valid_d;
`endif

  logic       sck_rise, sck_fall, ssel_assert, ssel_deassert;
  logic [7:0] rx_byte;

  // Reorder the response so tx_sr[63] is always the next bit on the wire:
  // byte 0 moves to the top, and each byte stays MSB first.
  function automatic logic [63:0] tx_order(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[63-8*i -: 8] = v[8*i +: 8];
    end
    return r;
  endfunction

  assign sck_rise      =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sck_fall      = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
  assign ssel_assert   = ~ssel_sync_q[SYNC_STAGES-1] &  ssel_prev_q;
  assign ssel_deassert =  ssel_sync_q[SYNC_STAGES-1] & ~ssel_prev_q;
  // MOSI is taken from the history flop, one clk behind the edge. The host
  // holds MOSI for half an SCK period, so the value is still the one that
  // was present at the edge.
  assign rx_byte       = {rx_sr_q[6:0], mosi_prev_q};

  always_comb begin
    sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    ssel_sync_d    = {ssel_sync_q[SYNC_STAGES-2:0], spi_ssel_n};
    mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d    = sclk_sync_q[SYNC_STAGES-1];
    ssel_prev_d    = ssel_sync_q[SYNC_STAGES-1];
    mosi_prev_d    = mosi_sync_q[SYNC_STAGES-1];
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    load_pend_d    = 1'b0;
    miso_d         = miso_q;
    cmd_d          = cmd_q;
    rxdata_d       = rxdata_q;
    msg_end_d      = 1'b0;
`ifdef SPI_RXBYTE_STREAM_EN
    rxbyte_d       = rxbyte_q;
    rxbyte_valid_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ssel_assert) begin
          state_d    = ST_CMD;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 4'd0;
          rx_sr_d    = 8'h00;
          tx_sr_d    = 64'h0;
          rxdata_d   = 64'h0;
        end
      end
      default: begin
        // Deassertion takes priority over a coincident SCK edge, which is dropped.
        if (ssel_deassert) begin
          state_d   = ST_IDLE;
          miso_d    = 1'b0;
          msg_end_d = (state_q == ST_DATA);
        end else begin
          // spi_cmd became visible last clk; the decoder's answer is valid now.
          if (load_pend_q) begin
            tx_sr_d = spi_txdata_valid ? tx_order(spi_txdata) : 64'h0;
          end
          if (sck_rise) begin
            rx_sr_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_CMD) begin
                cmd_d       = rx_byte;
                state_d     = ST_DATA;
                load_pend_d = 1'b1;
              end else begin
                rxdata_d = {rx_byte, rxdata_q[63:8]};
                if (byte_cnt_q != 4'd15) begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
                end
`ifdef SPI_RXBYTE_STREAM_EN
                rxbyte_d       = rx_byte;
                rxbyte_valid_d = 1'b1;
`endif
              end
            end
          end
          // The register fills with zeros from the bottom, so MISO reads 0
          // after all 64 response bits have gone out.
          if (sck_fall) begin
            if (state_q == ST_DATA) begin
              miso_d  = tx_sr_q[63];
              tx_sr_d = {tx_sr_q[62:0], 1'b0};
            end else begin
              miso_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sclk_sync_q    <= '0;
      ssel_sync_q    <= '0;
      mosi_sync_q    <= '0;
      sclk_prev_q    <= 1'b0;
      ssel_prev_q    <= 1'b0;
      mosi_prev_q    <= 1'b0;
      bit_cnt_q      <= 3'd0;
      byte_cnt_q     <= 4'd0;
      rx_sr_q        <= 8'h00;
      tx_sr_q        <= 64'h0;
      load_pend_q    <= 1'b0;
      miso_q         <= 1'b0;
      cmd_q          <= 8'h00;
      rxdata_q       <= 64'h0;
      msg_end_q      <= 1'b0;
`ifdef SPI_RXBYTE_STREAM_EN
      rxbyte_q       <= 8'h00;
      rxbyte_valid_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sclk_sync_q    <= sclk_sync_d;
      ssel_sync_q    <= ssel_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      sclk_prev_q    <= sclk_prev_d;
      ssel_prev_q    <= ssel_prev_d;
      mosi_prev_q    <= mosi_prev_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      rx_sr_q        <= rx_sr_d;
      tx_sr_q        <= tx_sr_d;
      load_pend_q    <= load_pend_d;
      miso_q         <= miso_d;
      cmd_q          <= cmd_d;
      rxdata_q       <= rxdata_d;
      msg_end_q      <= msg_end_d;
`ifdef SPI_RXBYTE_STREAM_EN
      rxbyte_q       <= rxbyte_d;
      rxbyte_valid_q <= rxbyte_valid_d;
`endif
    end
  end

  assign spi_miso         = miso_q;
  assign spi_cmd          = cmd_q;
  assign spi_rxdata       = rxdata_q;
  assign spi_msg_end      = msg_end_q;
`ifdef SPI_RXBYTE_STREAM_EN
  assign spi_rxbyte       = rxbyte_q;
  assign spi_rxbyte_valid = rxbyte_valid_q;
`endif

endmodule
